// File: rtl/serial_addr_decoder.sv
// Serial slave-address decoder: shifts an LSB-first address in while A_ADD/B_UTIL qualify it,
// then drives a one-hot registered select until SEL_CLR. Optional feature macro: ADDR_PARITY_EN.
module serial_addr_decoder #(
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_SLAVES = 3
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  A_ADD,
    input  logic                  B_UTIL,
    input  logic                  B_BUS_OUT,
    input  logic                  SEL_CLR,
    output logic [NUM_SLAVES-1:0] AD_SEL,
    output logic                  ADDR_VALID,
    output logic                  ADDR_ERR,
    output logic                  BUSY,
    output logic [1:0]            STATE_DBG
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

`ifdef ADDR_PARITY_EN
    localparam int NBITS = ADDR_WIDTH + 1;
`else
    localparam int NBITS = ADDR_WIDTH;
`endif
    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    state_t                  state_q, state_d;
    logic [NBITS-1:0]        sreg_q, sreg_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   ad_sel_q, ad_sel_d;
    logic                    addr_valid_q, addr_valid_d;
    logic                    addr_err_q, addr_err_d;

    logic [NBITS-1:0]        base_sreg, cap_sreg;
    logic [CW-1:0]           base_cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [NUM_SLAVES-1:0]   match;
    logic                    parity_ok;

    // Valid/ready-free handshake: a bit is consumed on every edge where A_ADD and B_UTIL are both
    // high while not in HOLD; SEL_CLR is only meaningful in HOLD.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        ad_sel_d     = ad_sel_q;
        addr_valid_d = 1'b0;
        addr_err_d   = 1'b0;

        // An IDLE-cycle sample lands in bit 0 of a freshly cleared register.
        base_sreg = (state_q == IDLE) ? '0 : sreg_q;
        base_cnt  = (state_q == IDLE) ? '0 : cnt_q;
        cap_sreg  = base_sreg;
        for (int i = 0; i < NBITS; i++) begin
            if (base_cnt == CW'(i)) begin
                cap_sreg[i] = B_BUS_OUT;
            end
        end
        addr = cap_sreg[ADDR_WIDTH-1:0];
`ifdef ADDR_PARITY_EN
        parity_ok = ~(^cap_sreg);
`else
        parity_ok = 1'b1;
`endif
        match = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = (addr == ADDR_WIDTH'(i + 1));
        end

        case (state_q)
            IDLE, SHIFT: begin
                if (!A_ADD) begin
                    if (state_q == SHIFT) begin
                        state_d  = IDLE;
                        sreg_d   = '0;
                        cnt_d    = '0;
                        ad_sel_d = '0;
                    end
                end else begin
                    state_d = SHIFT;
                    sreg_d  = base_sreg;
                    cnt_d   = base_cnt;
                    if (B_UTIL) begin
                        if (base_cnt == LAST_IDX) begin
                            sreg_d   = '0;
                            cnt_d    = '0;
                            ad_sel_d = '0;
                            state_d  = IDLE;
                            if (!parity_ok) begin
                                addr_err_d = 1'b1;
                            end else if (addr == '0) begin
                                state_d = IDLE;
                            end else if (match == '0) begin
                                addr_err_d = 1'b1;
                            end else begin
                                ad_sel_d     = match;
                                addr_valid_d = 1'b1;
                                state_d      = HOLD;
                            end
                        end else begin
                            sreg_d = cap_sreg;
                            cnt_d  = base_cnt + CW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (SEL_CLR) begin
                    ad_sel_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                sreg_d   = '0;
                cnt_d    = '0;
                ad_sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            ad_sel_q     <= '0;
            addr_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            ad_sel_q     <= ad_sel_d;
            addr_valid_q <= addr_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign AD_SEL     = ad_sel_q;
    assign ADDR_VALID = addr_valid_q;
    assign ADDR_ERR   = addr_err_q;
    assign BUSY       = (state_q != IDLE);
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_serial_addr_decoder.sv
// Bench for serial_addr_decoder: a 3-slave and a 2-slave instance share one stimulus stream;
// expected outputs of both are queued when the final address bit is driven.
module tb_serial_addr_decoder;

    logic clk, rstn, a_add, b_util, b_bus_out, sel_clr;
    logic [2:0] ad_sel;
    logic       addr_valid, addr_err, busy;
    logic [1:0] state_dbg;
    logic [1:0] ad_sel2;
    logic       addr_valid2, addr_err2, busy2;
    logic [1:0] state_dbg2;

    int n_cmp = 0;
    int n_fail = 0;
    logic [11:0] exp_q[$];

    serial_addr_decoder #(.ADDR_WIDTH(2), .NUM_SLAVES(3)) dut (
        .CLK(clk), .RSTN(rstn), .A_ADD(a_add), .B_UTIL(b_util), .B_BUS_OUT(b_bus_out),
        .SEL_CLR(sel_clr), .AD_SEL(ad_sel), .ADDR_VALID(addr_valid), .ADDR_ERR(addr_err),
        .BUSY(busy), .STATE_DBG(state_dbg)
    );

    serial_addr_decoder #(.ADDR_WIDTH(2), .NUM_SLAVES(2)) dut2 (
        .CLK(clk), .RSTN(rstn), .A_ADD(a_add), .B_UTIL(b_util), .B_BUS_OUT(b_bus_out),
        .SEL_CLR(sel_clr), .AD_SEL(ad_sel2), .ADDR_VALID(addr_valid2), .ADDR_ERR(addr_err2),
        .BUSY(busy2), .STATE_DBG(state_dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; a_add = 1'b0; b_util = 1'b0; b_bus_out = 1'b0; sel_clr = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // {dut: sel, valid, err, busy, pad, dut2: sel, valid, err, busy}
    function automatic logic [11:0] obs();
        return {ad_sel, addr_valid, addr_err, busy, 1'b0, ad_sel2, addr_valid2, addr_err2, busy2};
    endfunction

    function automatic logic [11:0] mk(input logic [2:0] s, input logic v, input logic e, input logic b,
                                       input logic [1:0] s2, input logic v2, input logic e2, input logic b2);
        return {s, v, e, b, 1'b0, s2, v2, e2, b2};
    endfunction

    // driver: address LSB first (plus even parity bit when enabled), waits after the first bit
    task automatic send_addr(input logic [1:0] a, input int waits, input bit clr_in_wait,
                             input bit bad_par, input logic [11:0] exp);
        logic [2:0] bits;
        int nb;
        bits = {(^a) ^ bad_par, a};
`ifdef ADDR_PARITY_EN
        nb = 3;
`else
        nb = 2;
`endif
        for (int i = 0; i < nb; i++) begin
            a_add = 1'b1; b_util = 1'b1; b_bus_out = bits[i];
            if (i == nb - 1) exp_q.push_back(exp);
            tick();
            if (i == 0) begin
                for (int w = 0; w < waits; w++) begin
                    b_util = 1'b0; b_bus_out = 1'($urandom_range(0, 1)); sel_clr = clr_in_wait;
                    tick();
                end
                sel_clr = 1'b0;
            end
        end
        a_add = 1'b0; b_util = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rstn = 1'b0; a_add = 1'b1; b_util = 1'b1; b_bus_out = 1'b1; sel_clr = 1'b1;
        tick();
        e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs(), e); end
        n_cmp++;
        if ({state_dbg, state_dbg2} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_state: got %b expected 0000", {state_dbg, state_dbg2});
        end
        a_add = 1'b0; b_util = 1'b0; b_bus_out = 1'b0; sel_clr = 1'b0; rstn = 1'b1;
        tick();
    endtask

    task automatic test_addr2_decode();
        logic [11:0] e;
        do_reset();
        send_addr(2'd2, 0, 0, 0, mk(3'b010, 1, 0, 1, 2'b10, 1, 0, 1));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL addr2_decode: got %b expected %b", obs(), e); end
        tick();
        e = mk(3'b010, 0, 0, 1, 2'b10, 0, 0, 1);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL addr2_single_pulse: got %b expected %b", obs(), e); end
        a_add = 1'b1; b_util = 1'b1; b_bus_out = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL hold_ignores_a_add: got %b expected %b", obs(), e); end
        a_add = 1'b0; b_util = 1'b0; sel_clr = 1'b1;
        tick();
        sel_clr = 1'b0;
        e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL sel_clr_release: got %b expected %b", obs(), e); end
    endtask

    task automatic test_wait_states();
        logic [11:0] e;
        do_reset();
        send_addr(2'd3, 3, 1, 0, mk(3'b100, 1, 0, 1, 2'b00, 0, 1, 0));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL wait_states_addr3: got %b expected %b", obs(), e); end
        tick();
        e = mk(3'b100, 0, 0, 1, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL err_single_pulse: got %b expected %b", obs(), e); end
        sel_clr = 1'b1;
        tick();
        sel_clr = 1'b0;
    endtask

    task automatic test_abort();
        logic [11:0] e;
        do_reset();
        a_add = 1'b1; b_util = 1'b1; b_bus_out = 1'b1;
        tick();
        e = mk(3'b000, 0, 0, 1, 2'b00, 0, 0, 1);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL shift_busy: got %b expected %b", obs(), e); end
        a_add = 1'b0; b_util = 1'b0;
        tick();
        e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL abort_idle: got %b expected %b", obs(), e); end
        tick();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL abort_no_pulse: got %b expected %b", obs(), e); end
    endtask

    task automatic test_addr0();
        logic [11:0] e;
        do_reset();
        send_addr(2'd0, 1, 0, 0, mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL addr0_silent: got %b expected %b", obs(), e); end
    endtask

    task automatic test_clr_priority();
        logic [11:0] e;
        do_reset();
        send_addr(2'd1, 0, 0, 0, mk(3'b001, 1, 0, 1, 2'b01, 1, 0, 1));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL addr1_decode: got %b expected %b", obs(), e); end
        sel_clr = 1'b1; a_add = 1'b1; b_util = 1'b1; b_bus_out = 1'b0;
        tick();
        sel_clr = 1'b0; a_add = 1'b0; b_util = 1'b0;
        e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL sel_clr_wins: got %b expected %b", obs(), e); end
        tick();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL after_clr_idle: got %b expected %b", obs(), e); end
    endtask

    task automatic test_reset_mid_phase();
        logic [11:0] e;
        do_reset();
        a_add = 1'b1; b_util = 1'b1; b_bus_out = 1'b1;
        tick();
        rstn = 1'b0; sel_clr = 1'b1;
        tick();
        rstn = 1'b1; a_add = 1'b0; b_util = 1'b0; sel_clr = 1'b0;
        e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_shift: got %b expected %b", obs(), e); end
        tick();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_shift_late: got %b expected %b", obs(), e); end
        send_addr(2'd2, 0, 0, 0, mk(3'b010, 1, 0, 1, 2'b10, 1, 0, 1));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL pre_reset_hold: got %b expected %b", obs(), e); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_hold: got %b expected %b", obs(), e); end
    endtask

`ifdef ADDR_PARITY_EN
    task automatic test_parity();
        logic [11:0] e;
        do_reset();
        send_addr(2'd1, 0, 0, 0, mk(3'b001, 1, 0, 1, 2'b01, 1, 0, 1));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL parity_good: got %b expected %b", obs(), e); end
        sel_clr = 1'b1;
        tick();
        sel_clr = 1'b0;
        send_addr(2'd1, 1, 0, 1, mk(3'b000, 0, 1, 0, 2'b00, 0, 1, 0));
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin n_fail++; $display("FAIL parity_bad: got %b expected %b", obs(), e); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [11:0] e;
        logic [1:0] a;
        logic [2:0] s;
        logic [1:0] s2;
        int w;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            a = 2'($urandom_range(0, 3));
            w = $urandom_range(0, 2);
            s  = (a == 2'd0) ? 3'b000 : (3'b001 << (a - 2'd1));
            s2 = (a == 2'd1) ? 2'b01 : ((a == 2'd2) ? 2'b10 : 2'b00);
            send_addr(a, w, 1'($urandom_range(0, 1)), 0,
                      mk(s, a != 2'd0, 1'b0, a != 2'd0, s2, s2 != 2'b00, a == 2'd3, s2 != 2'b00));
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL b2b_decode[%0d] addr=%0d: got %b expected %b", n, a, obs(), e);
            end
            sel_clr = 1'b1;
            tick();
            sel_clr = 1'b0;
            e = mk(3'b000, 0, 0, 0, 2'b00, 0, 0, 0);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL b2b_release[%0d]: got %b expected %b", n, obs(), e);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; a_add = 1'b0; b_util = 1'b0; b_bus_out = 1'b0; sel_clr = 1'b0;
        test_reset();
`ifdef ADDR_PARITY_EN
        test_parity();
`endif
        test_addr2_decode();
        test_wait_states();
        test_abort();
        test_addr0();
        test_clr_priority();
        test_reset_mid_phase();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addr_decoder.md
SERIAL_ADDR_DECODER -- requirements
Module: serial_addr_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2: serial slave-address bits per address phase, at least 1.
REQ-002 SHALL have parameter NUM_SLAVES, default 3: slave select lines, 1 to 2**ADDR_WIDTH-1.
REQ-003 SHALL have port CLK, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port RSTN, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port A_ADD, input, 1: arbiter address-phase enable.
REQ-006 SHALL have port B_UTIL, input, 1: bus-utilised qualifier; a bit is sampled only when A_ADD and B_UTIL are both high.
REQ-007 SHALL have port B_BUS_OUT, input, 1: serial address data, LSB first.
REQ-008 SHALL have port SEL_CLR, input, 1: transaction-complete strobe that releases the select.
REQ-009 SHALL have port AD_SEL, output, NUM_SLAVES: one-hot slave select, registered.
REQ-010 SHALL have port ADDR_VALID, output, 1: one-cycle pulse when a legal address is decoded.
REQ-011 SHALL have port ADDR_ERR, output, 1: one-cycle pulse on an illegal address or parity failure.
REQ-012 SHALL have port BUSY, output, 1: high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and HOLD, encoded in 2 bits.
REQ-014 In IDLE, A_ADD high SHALL move to SHIFT and clear the shift register and bit counter; a bit sampled in that same cycle SHALL be captured as bit 0.
REQ-015 In SHIFT, each sampled bit SHALL be written to addr[count] and the counter incremented; cycles with B_UTIL low SHALL insert wait states without losing data.
REQ-016 In SHIFT, A_ADD low before all bits are captured SHALL abort to IDLE with no ADDR_VALID, no ADDR_ERR and AD_SEL at zero.
REQ-017 On the edge sampling the final bit, the FSM SHALL decode the address: address k with 1 <= k <= NUM_SLAVES sets AD_SEL[k-1], pulses ADDR_VALID and moves to HOLD.
REQ-018 Address 0 SHALL return to IDLE with AD_SEL zero and no pulse; address k > NUM_SLAVES SHALL pulse ADDR_ERR, keep AD_SEL zero and return to IDLE.
REQ-019 Latency SHALL be: AD_SEL, ADDR_VALID and ADDR_ERR are visible in the cycle after the final bit is sampled.
REQ-020 In HOLD, AD_SEL SHALL stay constant and A_ADD SHALL be ignored until SEL_CLR is high, which zeroes AD_SEL and returns to IDLE on that edge.
REQ-021 SEL_CLR in IDLE or SHIFT SHALL have no effect.
REQ-022 If SEL_CLR and A_ADD are high together in HOLD, SEL_CLR SHALL win; a new address phase needs A_ADD high in IDLE.
REQ-023 AD_SEL SHALL never have more than one bit set.
REQ-024 The bit counter SHALL be $clog2(ADDR_WIDTH+1) bits wide and SHALL never wrap within a phase.

Reset
REQ-025 With RSTN low at a rising edge: state IDLE, AD_SEL zero, ADDR_VALID 0, ADDR_ERR 0, BUSY 0, shift register and counter zero.
REQ-026 Reset mid-SHIFT or mid-HOLD SHALL discard the partial or held address and produce no pulse.
REQ-027 Reset SHALL override every other input in the same cycle.

Configuration
REQ-028 Macro ADDR_PARITY_EN defined: SHIFT SHALL capture one extra bit after the address, even parity over address plus that bit.
REQ-029 With ADDR_PARITY_EN, a mismatch SHALL pulse ADDR_ERR, keep AD_SEL zero and return to IDLE; latency counts from the parity bit.
REQ-030 Macro ADDR_PARITY_EN undefined: no parity bit, and behaviour is exactly REQ-013 to REQ-024.

Verification (defaults NUM_SLAVES=3, ADDR_WIDTH=2, macro undefined unless stated)
REQ-031 A_ADD=B_UTIL=1 with bits 0,1 (addr 2) -> next cycle AD_SEL=3'b010, ADDR_VALID pulses once; SEL_CLR -> AD_SEL=0, BUSY=0.
REQ-032 Bits 1, then B_UTIL=0 for 3 cycles, then 1 (addr 3) -> AD_SEL=3'b100 one cycle after the last bit; wait cycles are harmless.
REQ-033 A_ADD drops after 1 bit -> IDLE, AD_SEL=0, no pulses; NUM_SLAVES=2 with addr 3 -> ADDR_ERR pulse, AD_SEL=0.
REQ-034 In HOLD with AD_SEL=3'b001, SEL_CLR and A_ADD high together -> IDLE, AD_SEL=0; RSTN=0 mid-SHIFT -> all outputs 0 next cycle.
REQ-035 ADDR_PARITY_EN defined: bits 1,0, parity 1 -> AD_SEL=3'b001; bits 1,0, parity 0 -> ADDR_ERR pulse, AD_SEL=0.
